// File: rtl/riscv_pkg.sv
// Types and constants shared by the front-end pipeline blocks.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] pc4;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fq_ram.sv
// Fetch-queue storage: one write port, one asynchronous read port, no reset on the array.
module fq_ram
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned EW = $bits(fq_entry_t)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [EW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [EW-1:0] o_rdata
);

  logic [EW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode; a taken redirect in Execute empties it.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 64,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned PW = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PC_F,
  input  logic [31:0]     Instr_F,
  input  logic            Valid_F,
  output logic            Ready_F,
  input  logic            PCSrc_E,
  output logic [XLEN-1:0] PC_D,
  output logic [XLEN-1:0] PCPlus4_D,
  output logic [31:0]     Instr_D,
  output logic            Valid_D,
  input  logic            Ready_D,
  output logic [PW-1:0]   Count
);

  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic            w_full, w_empty, w_push, w_pop;
  logic [XLEN-1:0] w_pc4;
  fq_entry_t       w_wdata, w_head;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign Ready_F = ~w_full;
  assign Valid_D = ~w_empty;
  assign w_push  = Valid_F & Ready_F & ~PCSrc_E;
  assign w_pop   = Valid_D & Ready_D & ~PCSrc_E;
  assign Count   = r_wr_ptr - r_rd_ptr;

  assign w_pc4 = PC_F + XLEN'(4);

  always_comb begin
    w_wdata       = '0;
    w_wdata.pc    = 64'(PC_F);
    w_wdata.pc4   = 64'(w_pc4);
    w_wdata.instr = Instr_F;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (PCSrc_E) begin
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  fq_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_head)
  );

  // An empty queue presents a bubble rather than stale storage.
  assign PC_D      = w_empty ? '0 : w_head.pc[XLEN-1:0];
  assign PCPlus4_D = w_empty ? '0 : w_head.pc4[XLEN-1:0];
  assign Instr_D   = w_empty ? NOP_INSTR : w_head.instr;

  assert property (@(posedge clk) disable iff (!rst) !(w_push && w_full));
  assert property (@(posedge clk) disable iff (!rst) !(w_pop && w_empty));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill, pop, flush, streaming wrap, mid-stream reset.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic [63:0] PC_F;
  logic [31:0] Instr_F;
  logic        Valid_F;
  logic        Ready_F;
  logic        PCSrc_E;
  logic [63:0] PC_D;
  logic [63:0] PCPlus4_D;
  logic [31:0] Instr_D;
  logic        Valid_D;
  logic        Ready_D;
  logic [2:0]  Count;

  int total = 0;
  int bad   = 0;

  fetch_queue #(
    .DEPTH (4),
    .XLEN  (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .PC_F      (PC_F),
    .Instr_F   (Instr_F),
    .Valid_F   (Valid_F),
    .Ready_F   (Ready_F),
    .PCSrc_E   (PCSrc_E),
    .PC_D      (PC_D),
    .PCPlus4_D (PCPlus4_D),
    .Instr_D   (Instr_D),
    .Valid_D   (Valid_D),
    .Ready_D   (Ready_D),
    .Count     (Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; PC_F = '0; Instr_F = '0; Valid_F = 1'b0; PCSrc_E = 1'b0; Ready_D = 1'b0;
    step();
    step();
    rst = 1'b1;
    chk("rst_count", 64'(Count), 64'd0);
    chk("rst_valid_d", 64'(Valid_D), 64'd0);
    chk("rst_ready_f", 64'(Ready_F), 64'd1);
    chk("rst_instr_nop", 64'(Instr_D), 64'h13);
    chk("rst_pc_d", PC_D, 64'd0);

    // Fill with decode stalled
    Valid_F = 1'b1;
    for (int i = 0; i < 4; i++) begin
      PC_F    = 64'(4 * i);
      Instr_F = 32'h00500093 + (32'(i) << 20);
      step();
      if (i == 0) begin
        chk("first_push_count", 64'(Count), 64'd1);
        chk("first_push_pc", PC_D, 64'h0);
      end
    end
    chk("full_count", 64'(Count), 64'd4);
    chk("full_ready_f", 64'(Ready_F), 64'd0);
    chk("full_pc_d", PC_D, 64'h0);
    chk("full_pc4_d", PCPlus4_D, 64'h4);
    chk("full_instr_d", 64'(Instr_D), 64'h00500093);
    PC_F = 64'h10; Instr_F = 32'hdeadbeef;
    step();
    chk("fifth_ignored_count", 64'(Count), 64'd4);

    // Pop while full: push held off
    Ready_D = 1'b1;
    step();
    chk("pop_full_count", 64'(Count), 64'd3);
    chk("pop_full_pc_d", PC_D, 64'h4);
    chk("pop_full_ready_f", 64'(Ready_F), 64'd1);
    PC_F = 64'h20; Instr_F = 32'h00900093;
    step();
    chk("pushpop_count", 64'(Count), 64'd3);
    chk("pushpop_pc_d", PC_D, 64'h8);
    chk("pushpop_instr_d", 64'(Instr_D), 64'h00700093);

    // Flush drops queue and the instruction on the fetch port
    PCSrc_E = 1'b1; PC_F = 64'h10; Instr_F = 32'h00a00093;
    step();
    PCSrc_E = 1'b0; Valid_F = 1'b0;
    chk("flush_count", 64'(Count), 64'd0);
    chk("flush_valid_d", 64'(Valid_D), 64'd0);
    chk("flush_pc_d", PC_D, 64'h0);
    chk("flush_instr_nop", 64'(Instr_D), 64'h13);
    step();
    chk("flush_no_ghost", 64'(Count), 64'd0);

    // Stream 10 PCs through with decode always ready
    Valid_F = 1'b1;
    for (int i = 0; i < 10; i++) begin
      PC_F    = 64'h100 + 64'(4 * i);
      Instr_F = 32'h00000093 | (32'(i) << 20);
      step();
      chk($sformatf("stream_pc_%0d", i), PC_D, 64'h100 + 64'(4 * i));
      chk($sformatf("stream_pc4_%0d", i), PCPlus4_D, 64'h104 + 64'(4 * i));
      chk($sformatf("stream_instr_%0d", i), 64'(Instr_D), 64'(32'h00000093 | (32'(i) << 20)));
      chk($sformatf("stream_count_%0d", i), 64'(Count), 64'd1);
    end
    Valid_F = 1'b0;
    step();
    chk("stream_drain_count", 64'(Count), 64'd0);
    step();
    chk("pop_empty_count", 64'(Count), 64'd0);

    // Mid-stream reset
    Ready_D = 1'b0; Valid_F = 1'b1;
    PC_F = 64'h180; step();
    PC_F = 64'h184; step();
    chk("pre_rst_count", 64'(Count), 64'd2);
    rst = 1'b0; PC_F = 64'h300;
    step();
    rst = 1'b1;
    chk("midrst_count", 64'(Count), 64'd0);
    chk("midrst_valid_d", 64'(Valid_D), 64'd0);
    chk("midrst_ready_f", 64'(Ready_F), 64'd1);
    PC_F = 64'h200; Instr_F = 32'h00b00093;
    step();
    chk("post_rst_pc_d", PC_D, 64'h200);
    chk("post_rst_pc4_d", PCPlus4_D, 64'h204);
    chk("post_rst_count", 64'(Count), 64'd1);

    // PC+4 wraps at 2^XLEN
    PC_F = 64'hFFFF_FFFF_FFFF_FFFC; Instr_F = 32'h00c00093;
    step();
    Valid_F = 1'b0; Ready_D = 1'b1;
    chk("wrap_head_still", PC_D, 64'h200);
    step();
    chk("wrap_pc_d", PC_D, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_pc4_d", PCPlus4_D, 64'h0);
    step();
    chk("final_count", 64'(Count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
